// File: rtl/life_pkg.sv
// Shared types for the Game of Life grid and the LED-matrix scanner FSM.
package life_pkg;

  localparam int unsigned GRID_N = 16;

  typedef logic [GRID_N-1:0] row_t;
  typedef row_t [GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    StLatch,
    StBlank,
    StShow
  } scan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/life_grid_scanner_if.sv
// Grid-in / LED-matrix-out bundle for life_grid_scanner.
// SCANNER_PWM_EN adds the brightness input.
interface life_grid_scanner_if;
  import life_pkg::*;

  grid_t      cellStatus;
  logic       freeze;
  row_t       row_sel;
  row_t       col_data;
  logic       frame_done;

`ifdef SCANNER_PWM_EN
  logic [3:0] brightness;

  modport master (
    output cellStatus, freeze, brightness,
    input  row_sel, col_data, frame_done
  );
  modport slave (
    input  cellStatus, freeze, brightness,
    output row_sel, col_data, frame_done
  );
`else
  modport master (
    output cellStatus, freeze,
    input  row_sel, col_data, frame_done
  );
  modport slave (
    input  cellStatus, freeze,
    output row_sel, col_data, frame_done
  );
`endif

endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module scan_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/life_grid_scanner.sv
// Snapshots the life grid once per frame and row-multiplexes it onto a 16x16 LED matrix.
// Optional SCANNER_PWM_EN gates the columns with a 4-bit brightness duty cycle.
module life_grid_scanner
  import life_pkg::*;
#(
  parameter int unsigned DWELL = 2048,
  parameter int unsigned BLANK = 64
) (
  input logic               clk,
  input logic               reset,
  life_grid_scanner_if.slave bus
);

  localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned BlankW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int unsigned CntW   = max_u(DwellW, BlankW);

  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'((BLANK > 0) ? BLANK - 1 : 0);
  // Phase entered after LATCH or after a row: BLANK, or straight to SHOW when BLANK is 0.
  localparam logic [CntW-1:0] GapLoad   = (BLANK > 0) ? BlankLoad : DwellLoad;

  scan_state_t     state_q;
  logic [3:0]      row_q, row_nxt;
  grid_t           snap_q, latch_grid;
  row_t            row_sel_q, col_data_q;
  logic            frame_done_q;
  logic            tmr_load, tmr_tc, show_on;
  logic [CntW-1:0] tmr_val;

  always_comb begin
    row_nxt    = row_q + 4'd1;
    latch_grid = bus.freeze ? snap_q : bus.cellStatus;
    tmr_load   = 1'b0;
    tmr_val    = GapLoad;
    case (state_q)
      StLatch: tmr_load = 1'b1;
      StBlank: begin
        tmr_load = tmr_tc;
        tmr_val  = DwellLoad;
      end
      StShow:  tmr_load = tmr_tc;
      default: tmr_load = 1'b1;
    endcase
  end

`ifdef SCANNER_PWM_EN
  logic [3:0] bright_q, bright_cur, phase_q, phase_d;

  // show_on decides the column gate for the cycle being registered next.
  always_comb begin
    bright_cur = (state_q == StLatch) ? bus.brightness : bright_q;
    phase_d    = (state_q == StShow && !tmr_tc) ? phase_q + 4'd1 : 4'd0;
    show_on    = (phase_d < bright_cur);
  end
`else
  assign show_on = 1'b1;
`endif

  scan_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLatch;
      row_q        <= '0;
      snap_q       <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef SCANNER_PWM_EN
      bright_q     <= '0;
      phase_q      <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
`ifdef SCANNER_PWM_EN
      phase_q      <= phase_d;
`endif
      case (state_q)
        StLatch: begin
          snap_q <= latch_grid;
          row_q  <= '0;
`ifdef SCANNER_PWM_EN
          bright_q <= bus.brightness;
`endif
          if (BLANK > 0) begin
            state_q    <= StBlank;
            row_sel_q  <= '0;
            col_data_q <= '0;
          end else begin
            state_q    <= StShow;
            row_sel_q  <= row_t'(1);
            col_data_q <= show_on ? latch_grid[0] : '0;
          end
        end
        StBlank: begin
          if (tmr_tc) begin
            state_q    <= StShow;
            row_sel_q  <= row_t'(1) << row_q;
            col_data_q <= show_on ? snap_q[row_q] : '0;
          end
        end
        StShow: begin
          if (tmr_tc) begin
            if (row_q == 4'd15) begin
              state_q      <= StLatch;
              frame_done_q <= 1'b1;
              row_sel_q    <= '0;
              col_data_q   <= '0;
            end else begin
              row_q <= row_nxt;
              if (BLANK > 0) begin
                state_q    <= StBlank;
                row_sel_q  <= '0;
                col_data_q <= '0;
              end else begin
                row_sel_q  <= row_t'(1) << row_nxt;
                col_data_q <= show_on ? snap_q[row_nxt] : '0;
              end
            end
          end else begin
`ifdef SCANNER_PWM_EN
            col_data_q <= show_on ? snap_q[row_q] : '0;
`endif
          end
        end
        default: begin
          state_q    <= StLatch;
          row_sel_q  <= '0;
          col_data_q <= '0;
        end
      endcase
    end
  end

  assign bus.row_sel    = row_sel_q;
  assign bus.col_data   = col_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
